two_cycle_subtractor: RTL and testbench
=======================================

TWO_CYCLE_SUBTRACTOR -- requirements
Module: two_cycle_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter LO_WIDTH, default 16, giving the width of the low half computed in the first stage; legal range 1..WIDTH-1.
REQ-003 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1: synchronous, active-high reset.
REQ-005 Port a_i, input, WIDTH: minuend.
REQ-006 Port b_i, input, WIDTH: subtrahend.
REQ-007 Port valid_i, input, 1: operands present on a_i/b_i.
REQ-008 Port ready_o, output, 1: block can accept an operation this cycle.
REQ-009 Port valid_o, output, 1: one-cycle pulse, result outputs updated.
REQ-010 Port res_o, output, WIDTH: (a - b) mod 2^WIDTH.
REQ-011 Port borrow_o, output, 1: set when a < b, both unsigned.
REQ-012 Port zero_o, output, 1: set when res_o == 0.

Function
REQ-013 An operation SHALL be accepted on a rising edge where valid_i && ready_o; a_i and b_i SHALL be registered on that edge. This edge is edge N.
REQ-014 valid_i while ready_o is low SHALL be ignored, with no effect on registered operands or results.
REQ-015 The FSM SHALL have one-hot states IDLE, LOW_STAGE and HIGH_STAGE.
REQ-016 The FSM SHALL make these transitions and no others:
- IDLE -> LOW_STAGE on accept.
- LOW_STAGE -> HIGH_STAGE unconditionally.
- HIGH_STAGE -> IDLE unconditionally.
REQ-017 ready_o SHALL be high only in IDLE.
REQ-018 Edge N+1 (in LOW_STAGE) SHALL compute res_o[LO_WIDTH-1:0] = a_lo - b_lo and register the internal low-half borrow.
REQ-019 Edge N+2 (in HIGH_STAGE) SHALL perform all of the following:
- compute res_o[WIDTH-1:LO_WIDTH] = a_hi - b_hi - low_borrow;
- set borrow_o to the borrow out of the MSB;
- set zero_o to whether the full result is 0.
REQ-020 No single-cycle carry/borrow path SHALL span more than max(LO_WIDTH, WIDTH-LO_WIDTH)+1 bits.
REQ-021 valid_o SHALL be high exactly in the cycle after edge N+2, one cycle only.
REQ-022 Latency SHALL be fixed: valid_o rises 2 cycles after the accepting edge.
REQ-023 Throughput SHALL be at most one operation per 3 cycles; with valid_i held high, accepts SHALL occur at edges N, N+3, N+6, ...
REQ-024 res_o, borrow_o and zero_o SHALL hold their values from edge N+2 until the HIGH_STAGE edge of the next operation.
REQ-025 The low half of res_o MAY change at the next operation's LOW_STAGE edge; consumers SHALL sample only on valid_o.
REQ-026 Wrap-around: results SHALL be modulo 2^WIDTH with no saturation; borrow_o is the only underflow indicator.

Reset
REQ-027 While rst_i is high at a rising edge, the block SHALL load the following:
- state = IDLE;
- valid_o = 0;
- res_o = 0;
- borrow_o = 0;
- zero_o = 0;
- the internal low borrow = 0.
REQ-028 ready_o SHALL be 1 in the cycle after reset deasserts.
REQ-029 Reset in LOW_STAGE or HIGH_STAGE SHALL abort the operation; no valid_o SHALL follow for it.
REQ-030 rst_i SHALL take priority over an accept on the same edge; the operation is not accepted.
REQ-031 The power-up state without reset is undefined; the bench SHALL apply reset first.

Verification
REQ-032 Cross-half borrow: a=0x0001_0000, b=0x0000_0001 -> valid_o 2 cycles after accept; res_o=0x0000_FFFF, borrow_o=0, zero_o=0.
REQ-033 Underflow: a=5, b=7 -> res_o=0xFFFF_FFFE, borrow_o=1, zero_o=0; and a=0, b=0xFFFF_FFFF -> res_o=0x0000_0001, borrow_o=1.
REQ-034 Equality: a=b=0x1234_5678 -> res_o=0, zero_o=1, borrow_o=0.
REQ-035 Streaming: valid_i held high for 9 cycles with operands changing every cycle -> exactly 3 accepts at 3-cycle spacing, 3 valid_o pulses, each result matching the operands present at its accept edge.
REQ-036 Reset mid-op: accept a=10, b=3, then assert rst_i for one cycle in LOW_STAGE -> no valid_o pulse; res_o=0, borrow_o=0, zero_o=0; ready_o=1 in the cycle after reset.
REQ-037 Ignore while busy: valid_i pulsed with a=1, b=2 while ready_o=0 -> output of the in-flight operation unaffected; no extra valid_o.

Source files
------------

// File: rtl/two_cycle_subtractor.sv
// Two-stage unsigned subtractor: low half on the first stage edge, high half plus
// borrow/zero flags on the second, so no borrow chain spans the full operand width.
//
// state      | meaning
// IDLE       | ready_o high, waiting for valid_i
// LOW_STAGE  | operands held, low half being subtracted
// HIGH_STAGE | high half and flags being resolved, valid_o follows
module two_cycle_subtractor #(
    parameter int WIDTH    = 32,
    parameter int LO_WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] res_o,
    output logic             borrow_o,
    output logic             zero_o
);
    localparam int HI_WIDTH = WIDTH - LO_WIDTH;

    typedef enum logic [2:0] {
        IDLE       = 3'b001,
        LOW_STAGE  = 3'b010,
        HIGH_STAGE = 3'b100
    } state_t;

    state_t state, state_next;
    logic   accept;

    logic [WIDTH-1:0]  a_q, b_q;
    logic              lo_borrow;
    logic [LO_WIDTH:0] diff_lo;
    logic [HI_WIDTH:0] diff_hi;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    accept     = 1'b1;
                    state_next = LOW_STAGE;
                end
            end
            LOW_STAGE:  state_next = HIGH_STAGE;
            HIGH_STAGE: state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Extra top bit of each difference is the borrow out of that half.
    assign diff_lo = {1'b0, a_q[LO_WIDTH-1:0]} - {1'b0, b_q[LO_WIDTH-1:0]};
    assign diff_hi = {1'b0, a_q[WIDTH-1:LO_WIDTH]} - {1'b0, b_q[WIDTH-1:LO_WIDTH]}
                     - {{HI_WIDTH{1'b0}}, lo_borrow};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            lo_borrow <= 1'b0;
            res_o     <= '0;
            borrow_o  <= 1'b0;
            zero_o    <= 1'b0;
            valid_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (accept) begin
                a_q <= a_i;
                b_q <= b_i;
            end
            if (state == LOW_STAGE) begin
                res_o[LO_WIDTH-1:0] <= diff_lo[LO_WIDTH-1:0];
                lo_borrow           <= diff_lo[LO_WIDTH];
            end
            if (state == HIGH_STAGE) begin
                res_o[WIDTH-1:LO_WIDTH] <= diff_hi[HI_WIDTH-1:0];
                borrow_o                <= diff_hi[HI_WIDTH];
                zero_o                  <= (diff_hi[HI_WIDTH-1:0] == '0) &&
                                           (res_o[LO_WIDTH-1:0] == '0);
                valid_o                 <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_two_cycle_subtractor.sv
// Scoreboard bench for two_cycle_subtractor: expected results queued at accept,
// compared (including latency) whenever valid_o is seen.
module tb_two_cycle_subtractor;
    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [W-1:0] a_i, b_i;
    logic         valid_i;
    logic         ready_o, valid_o, borrow_o, zero_o;
    logic [W-1:0] res_o;

    two_cycle_subtractor #(.WIDTH(W), .LO_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .valid_i(valid_i),
        .ready_o(ready_o), .valid_o(valid_o), .res_o(res_o),
        .borrow_o(borrow_o), .zero_o(zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] res;
        logic         borrow;
        logic         zero;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   acc_cyc[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   n_push = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        if (valid_o === 1'b1) begin
            exp_t e;
            n_valid++;
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 64'(valid_o), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("res", 64'(res_o), 64'(e.res));
                check("borrow", 64'(borrow_o), 64'(e.borrow));
                check("zero", 64'(zero_o), 64'(e.zero));
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge; applies inputs for one cycle and returns at the next negedge.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic v,
                         output logic acc);
        exp_t e;
        a_i     = a;
        b_i     = b;
        valid_i = v;
        acc     = v && ready_o && !rst_i;
        if (acc) begin
            e.res    = a - b;
            e.borrow = (a < b);
            e.zero   = (a == b);
            e.cyc    = cyc + 3;
            sb_q.push_back(e);
            acc_cyc.push_back(cyc);
            n_push++;
        end
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive('0, '0, 1'b0, acc);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        drive(a, b, 1'b1, acc);
        check("op_accepted", 64'(acc), 64'd1);
        idle(2);
    endtask

    initial begin
        logic acc;
        int   base_acc, base_valid, base_push;

        rst_i = 1'b1; valid_i = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_res", 64'(res_o), 64'd0);
        check("rst_borrow", 64'(borrow_o), 64'd0);
        check("rst_zero", 64'(zero_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_rst", 64'(ready_o), 64'd1);

        do_op(32'h0001_0000, 32'h0000_0001);
        do_op(32'd5, 32'd7);
        do_op(32'h0000_0000, 32'hFFFF_FFFF);
        do_op(32'h1234_5678, 32'h1234_5678);
        do_op(32'hFFFF_FFFF, 32'h0000_0000);
        do_op(32'h8000_0000, 32'h0000_FFFF);
        idle(2);

        for (int i = 0; i < 20; i++) begin
            do_op($urandom, $urandom);
            idle($urandom_range(0, 2));
        end

        // Streaming: valid held high for 9 cycles with changing operands.
        idle(2);
        base_acc   = acc_cyc.size();
        base_valid = n_valid;
        base_push  = n_push;
        for (int i = 0; i < 9; i++) drive($urandom, $urandom, 1'b1, acc);
        idle(4);
        check("stream_accepts", 64'(n_push - base_push), 64'd3);
        check("stream_valids", 64'(n_valid - base_valid), 64'd3);
        if (acc_cyc.size() >= base_acc + 3) begin
            check("stream_gap1", 64'(acc_cyc[base_acc+1] - acc_cyc[base_acc]), 64'd3);
            check("stream_gap2", 64'(acc_cyc[base_acc+2] - acc_cyc[base_acc+1]), 64'd3);
        end

        // Ignore while busy: the in-flight result must stay intact.
        drive(32'd100, 32'd40, 1'b1, acc);
        check("busy_first_acc", 64'(acc), 64'd1);
        check("busy_ready", 64'(ready_o), 64'd0);
        drive(32'd1, 32'd2, 1'b1, acc);
        check("busy_ignored", 64'(acc), 64'd0);
        idle(4);

        // Reset during LOW_STAGE aborts the operation.
        a_i = 32'd10; b_i = 32'd3; valid_i = 1'b1;
        @(negedge clk_i);
        check("abort_in_low", 64'(ready_o), 64'd0);
        valid_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_ready", 64'(ready_o), 64'd1);
        check("abort_res", 64'(res_o), 64'd0);
        check("abort_borrow", 64'(borrow_o), 64'd0);
        check("abort_zero", 64'(zero_o), 64'd0);
        check("abort_valid", 64'(valid_o), 64'd0);
        idle(4);

        // Reset wins over a simultaneous accept.
        rst_i = 1'b1; valid_i = 1'b1; a_i = 32'd9; b_i = 32'd4;
        @(negedge clk_i);
        rst_i = 1'b0; valid_i = 1'b0;
        check("rst_priority_ready", 64'(ready_o), 64'd1);
        idle(4);

        do_op(32'd20, 32'd21);
        idle(3);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("valid_count", 64'(n_valid), 64'(n_push));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
